// File: rtl/press_gen_pkg.sv
// Shared types and constants for the press generator: FSM states, LFSR
// constants and the hold/gap counter width helper.
package press_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int             LFSR_W     = 10;
  localparam logic [9:0]     LFSR_SEED  = 10'h2A5;
  // Bit indices of the x^10 + x^7 + 1 feedback taps.
  localparam int             LFSR_TAP_A = 9;
  localparam int             LFSR_TAP_B = 6;

  function automatic int cnt_width(input int hold_cycles, input int gap_cycles);
    int m;
    m = (hold_cycles > gap_cycles) ? hold_cycles : gap_cycles;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/press_gen_if.sv
// Request/status bundle between a press requester (master) and press_gen (slave).
interface press_gen_if #(
  parameter int PEND_W = 3
);
  // fire is fire-and-forget: every high cycle is one request and is never
  // stalled; back-pressure shows up only as pending growth and overflow pulses.
  logic              en;
  logic              fire;
  logic              press;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              overflow;

  modport master (
    output en,
    output fire,
    input  press,
    input  busy,
    input  pending,
    input  overflow
  );

  modport slave (
    input  en,
    input  fire,
    output press,
    output busy,
    output pending,
    output overflow
  );
endinterface

// File: rtl/press_gen_lfsr10.sv
// 10-bit maximal-length Fibonacci LFSR (x^10 + x^7 + 1); advances only when en=1
// and returns to the fixed seed on reset.
module lfsr10
  import press_gen_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic [9:0] q
);

  logic fb;
  assign fb = q[LFSR_TAP_A] ^ q[LFSR_TAP_B];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= LFSR_SEED;
    end else if (en) begin
      q <= {q[8:0], fb};
    end
  end

endmodule

// File: rtl/press_gen.sv
// Turns single-cycle fire requests into button-like press pulses (HOLD high, GAP low)
// with a saturating queue. Optional AUTO_PLAYER_EN adds an LFSR-driven request source.
module press_gen
  import press_gen_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int PEND_W      = 3
) (
  input  logic        clk,
  input  logic        reset,
`ifdef AUTO_PLAYER_EN
  input  logic [1:0]  level,
`endif
  press_gen_if.slave  bus,
  output state_t      dbg_state
);

  localparam int                CNT_W     = cnt_width(HOLD_CYCLES, GAP_CYCLES);
  localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [PEND_W-1:0] pending_q, pending_nxt;
  logic              overflow_q, overflow_nxt;
  logic              press_q, busy_q;
  logic              req, has_pend, can_launch, launch, inc, dec;

`ifdef AUTO_PLAYER_EN
  logic [9:0] lfsr_q;
  logic       auto_req;
  logic       lfsr_unused;

  lfsr10 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (bus.en),
    .q     (lfsr_q)
  );

  assign auto_req    = bus.en & (lfsr_q[3:0] < {level, 2'b00});
  assign lfsr_unused = ^lfsr_q[9:4];
  assign req         = bus.fire | auto_req;
`else
  assign req = bus.fire;
`endif

  // Launches happen only from IDLE or on the final GAP cycle, which is what
  // guarantees the minimum low gap between presses.
  assign has_pend   = (pending_q != '0);
  assign can_launch = (state == IDLE) || ((state == GAP) && (cnt == '0));
  assign launch     = can_launch & bus.en & (req | has_pend);
  assign dec        = launch & has_pend;
  assign inc        = req & ~(launch & ~has_pend);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (launch) begin
          state_nxt = HOLD;
          cnt_nxt   = HOLD_LOAD;
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          state_nxt = GAP;
          cnt_nxt   = GAP_LOAD;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt == '0) begin
          if (launch) begin
            state_nxt = HOLD;
            cnt_nxt   = HOLD_LOAD;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // A simultaneous enqueue and dequeue leaves the count unchanged.
  always_comb begin
    pending_nxt  = pending_q;
    overflow_nxt = 1'b0;
    if (inc && !dec) begin
      if (pending_q == PEND_MAX) begin
        overflow_nxt = 1'b1;
      end else begin
        pending_nxt = pending_q + PEND_W'(1);
      end
    end else if (dec && !inc) begin
      pending_nxt = pending_q - PEND_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
      press_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      pending_q  <= pending_nxt;
      overflow_q <= overflow_nxt;
      press_q    <= (state_nxt == HOLD);
      busy_q     <= (state_nxt != IDLE);
    end
  end

  assign bus.press    = press_q;
  assign bus.busy     = busy_q;
  assign bus.pending  = pending_q;
  assign bus.overflow = overflow_q;
  assign dbg_state    = state;

endmodule

// File: tb/tb_press_gen.sv
// Directed bench for press_gen with default HOLD=4, GAP=2, PEND_W=3.
// Inputs change 1ns after posedge; outputs are sampled on the negedge.
module tb_press_gen;
  import press_gen_pkg::*;

  logic   clk;
  logic   reset;
  state_t dbg_state;
  int     n_checks;
  int     n_fail;

  press_gen_if #(.PEND_W(3)) bus ();

`ifdef AUTO_PLAYER_EN
  logic [1:0] level;
  press_gen dut (
    .clk       (clk),
    .reset     (reset),
    .level     (level),
    .bus       (bus),
    .dbg_state (dbg_state)
  );
`else
  press_gen dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );
`endif

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    bus.en   = 1'b0;
    bus.fire = 1'b0;
`ifdef AUTO_PLAYER_EN
    level = 2'd0;
`endif
    repeat (3) next_cycle();
    @(negedge clk);
    n_checks++;
    if (bus.press !== 1'b0) begin
      n_fail++; $display("FAIL reset_press: got %0b expected 0", bus.press);
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy: got %0b expected 0", bus.busy);
    end
    n_checks++;
    if (bus.pending !== 3'd0) begin
      n_fail++; $display("FAIL reset_pending: got %0d expected 0", bus.pending);
    end
    n_checks++;
    if (bus.overflow !== 1'b0) begin
      n_fail++; $display("FAIL reset_overflow: got %0b expected 0", bus.overflow);
    end
    n_checks++;
    if (dbg_state !== IDLE) begin
      n_fail++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE);
    end
    next_cycle();
    reset = 1'b1;
    next_cycle();
  endtask

  // One fire at cycle 5: press high 6..9, busy high 6..11.
  task automatic test_single();
    logic exp_p, exp_b;
    bus.en = 1'b1;
    for (int c = 0; c < 15; c++) begin
      bus.fire = (c == 5);
      exp_p = (c >= 6) && (c <= 9);
      exp_b = (c >= 6) && (c <= 11);
      @(negedge clk);
      n_checks++;
      if (bus.press !== exp_p) begin
        n_fail++; $display("FAIL single_press c%0d: got %0b expected %0b", c, bus.press, exp_p);
      end
      n_checks++;
      if (bus.busy !== exp_b) begin
        n_fail++; $display("FAIL single_busy c%0d: got %0b expected %0b", c, bus.busy, exp_b);
      end
      n_checks++;
      if (bus.pending !== 3'd0) begin
        n_fail++; $display("FAIL single_pending c%0d: got %0d expected 0", c, bus.pending);
      end
      next_cycle();
    end
    bus.fire = 1'b0;
  endtask

  // Three consecutive fires: presses at 1-4, 7-10, 13-16 with 2-cycle gaps.
  task automatic test_back_to_back();
    logic exp_p;
    bus.en = 1'b1;
    for (int c = 0; c < 20; c++) begin
      bus.fire = (c < 3);
      exp_p = ((c >= 1) && (c <= 4)) || ((c >= 7) && (c <= 10)) || ((c >= 13) && (c <= 16));
      @(negedge clk);
      n_checks++;
      if (bus.press !== exp_p) begin
        n_fail++; $display("FAIL b2b_press c%0d: got %0b expected %0b", c, bus.press, exp_p);
      end
      if (c == 2 || c == 3 || c == 7 || c == 13) begin
        logic [2:0] exp_pend;
        exp_pend = (c == 2) ? 3'd1 : (c == 3) ? 3'd2 : (c == 7) ? 3'd1 : 3'd0;
        n_checks++;
        if (bus.pending !== exp_pend) begin
          n_fail++; $display("FAIL b2b_pending c%0d: got %0d expected %0d", c, bus.pending, exp_pend);
        end
      end
      if (c == 19) begin
        n_checks++;
        if (bus.busy !== 1'b0) begin
          n_fail++; $display("FAIL b2b_idle_busy: got %0b expected 0", bus.busy);
        end
      end
      next_cycle();
    end
    bus.fire = 1'b0;
  endtask

  // Fire held for cycles 0..10: queue fills to 7 at cycle 9, fires at 9 and 10
  // are dropped (overflow at 10 and 11), 9 presses emitted in total.
  task automatic test_overflow();
    int   rises, ovf_cnt;
    logic prev_p;
    rises = 0; ovf_cnt = 0; prev_p = 1'b0;
    bus.en = 1'b1;
    for (int c = 0; c < 62; c++) begin
      bus.fire = (c <= 10);
      @(negedge clk);
      if (bus.press && !prev_p) rises++;
      prev_p = bus.press;
      if (bus.overflow) ovf_cnt++;
      if (c == 9) begin
        n_checks++;
        if (bus.pending !== 3'd7) begin
          n_fail++; $display("FAIL ovf_pending_max: got %0d expected 7", bus.pending);
        end
      end
      if (c >= 10 && c <= 12) begin
        logic exp_o;
        exp_o = (c != 12);
        n_checks++;
        if (bus.overflow !== exp_o) begin
          n_fail++; $display("FAIL ovf_pulse c%0d: got %0b expected %0b", c, bus.overflow, exp_o);
        end
      end
      next_cycle();
    end
    bus.fire = 1'b0;
    n_checks++;
    if (rises !== 9) begin
      n_fail++; $display("FAIL ovf_press_count: got %0d expected 9", rises);
    end
    n_checks++;
    if (ovf_cnt !== 2) begin
      n_fail++; $display("FAIL ovf_pulse_count: got %0d expected 2", ovf_cnt);
    end
    n_checks++;
    if (bus.pending !== 3'd0) begin
      n_fail++; $display("FAIL ovf_drained: got %0d expected 0", bus.pending);
    end
  endtask

  // en dropped at cycle 3 with 2 queued: press finishes, queue held, then drains.
  task automatic test_en_pause();
    int   rises;
    logic prev_p;
    rises = 0; prev_p = 1'b0;
    for (int c = 0; c < 25; c++) begin
      bus.fire = (c < 3);
      bus.en   = (c < 3);
      @(negedge clk);
      if (c >= 5) begin
        n_checks++;
        if (bus.press !== 1'b0) begin
          n_fail++; $display("FAIL pause_press c%0d: got %0b expected 0", c, bus.press);
        end
      end
      if (c == 24) begin
        n_checks++;
        if (bus.pending !== 3'd2) begin
          n_fail++; $display("FAIL pause_pending: got %0d expected 2", bus.pending);
        end
        n_checks++;
        if (bus.busy !== 1'b0) begin
          n_fail++; $display("FAIL pause_busy: got %0b expected 0", bus.busy);
        end
      end
      next_cycle();
    end
    bus.fire = 1'b0;
    bus.en   = 1'b1;
    for (int c = 25; c < 45; c++) begin
      @(negedge clk);
      if (bus.press && !prev_p) rises++;
      prev_p = bus.press;
      if (c == 26) begin
        n_checks++;
        if (bus.pending !== 3'd1) begin
          n_fail++; $display("FAIL resume_pending: got %0d expected 1", bus.pending);
        end
      end
      next_cycle();
    end
    n_checks++;
    if (rises !== 2) begin
      n_fail++; $display("FAIL resume_press_count: got %0d expected 2", rises);
    end
    n_checks++;
    if (bus.pending !== 3'd0) begin
      n_fail++; $display("FAIL resume_drained: got %0d expected 0", bus.pending);
    end
  endtask

  // Reset asserted between edges during HOLD with one request queued.
  task automatic test_async_reset();
    bus.en = 1'b1;
    for (int c = 0; c < 3; c++) begin
      bus.fire = (c < 2);
      next_cycle();
    end
    bus.fire = 1'b0;
    #2;
    n_checks++;
    if (bus.press !== 1'b1 || bus.pending !== 3'd1) begin
      n_fail++; $display("FAIL arst_pre: got press=%0b pending=%0d expected press=1 pending=1", bus.press, bus.pending);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus.press !== 1'b0) begin
      n_fail++; $display("FAIL arst_press: got %0b expected 0", bus.press);
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL arst_busy: got %0b expected 0", bus.busy);
    end
    n_checks++;
    if (bus.pending !== 3'd0) begin
      n_fail++; $display("FAIL arst_pending: got %0d expected 0", bus.pending);
    end
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (dbg_state !== IDLE || bus.press !== 1'b0) begin
      n_fail++; $display("FAIL arst_release: got state=%0d press=%0b expected state=%0d press=0", dbg_state, bus.press, IDLE);
    end
    next_cycle();
  endtask

  // Five randomly spaced fires through a rising-edge detector: five pulls.
  task automatic test_chain();
    int   pulls, gap;
    logic prev_p;
    pulls = 0; prev_p = 1'b0;
    bus.en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      gap = $urandom_range(0, 8);
      for (int c = 0; c <= gap; c++) begin
        bus.fire = (c == 0);
        @(negedge clk);
        if (bus.press && !prev_p) pulls++;
        prev_p = bus.press;
        next_cycle();
      end
    end
    bus.fire = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.press && !prev_p) pulls++;
      prev_p = bus.press;
      next_cycle();
    end
    n_checks++;
    if (pulls !== 5) begin
      n_fail++; $display("FAIL chain_pulls: got %0d expected 5", pulls);
    end
  endtask

`ifdef AUTO_PLAYER_EN
  task automatic test_auto_level0();
    int highs;
    highs = 0;
    level  = 2'd0;
    bus.en = 1'b1;
    bus.fire = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (bus.press) highs++;
      next_cycle();
    end
    n_checks++;
    if (highs !== 0) begin
      n_fail++; $display("FAIL auto_level0: got %0d high cycles expected 0", highs);
    end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_en_pause();
    test_async_reset();
    test_chain();
`ifdef AUTO_PLAYER_EN
    test_auto_level0();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
